// File: rtl/serial_subtractor.sv
// serial_subtractor: digit-serial a - b - borrow_in, DIGIT bits per clock.
// Operands are captured on start; one DIGIT-bit slice is subtracted per RUN
// cycle from LSB to MSB, and the result is published together on entry to DONE.
// Optional build macro SERIAL_SUBTRACTOR_SAT_EN: on final borrow the result
// saturates to zero (zero_out=1, borrow_out still 1) instead of wrapping.
//
// state  | meaning
// IDLE   | waiting for start_in
// RUN    | subtracting one slice per clock, N cycles
// DONE   | result valid, done_out pulse; start_in may chain a new operation
module serial_subtractor #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             borrow_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic             zero_out
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow_out;
  logic             r_zero;

  logic [DIGIT:0]   w_slice;
  logic [DIGIT-1:0] w_slice_diff;
  logic             w_slice_borrow;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_final_diff;
  logic             w_last;

  // One slice: the extra top bit of the (DIGIT+1)-bit difference is the borrow.
  assign w_slice        = {1'b0, r_a[DIGIT-1:0]} - {1'b0, r_b[DIGIT-1:0]}
                          - {{DIGIT{1'b0}}, r_borrow};
  assign w_slice_diff   = w_slice[DIGIT-1:0];
  assign w_slice_borrow = w_slice[DIGIT];

  // Result accumulates from the top down so that after N slices it is aligned.
  assign w_acc_next = (r_acc >> DIGIT) | (WIDTH'(w_slice_diff) << (WIDTH - DIGIT));
  assign w_last     = (r_cnt == CW'(N - 1));

`ifdef SERIAL_SUBTRACTOR_SAT_EN
  assign w_final_diff = w_slice_borrow ? '0 : w_acc_next;
`else
  assign w_final_diff = w_acc_next;
`endif

  // Sequencing FSM, operand shifters and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_a          <= '0;
      r_b          <= '0;
      r_acc        <= '0;
      r_borrow     <= 1'b0;
      r_cnt        <= '0;
      r_diff       <= '0;
      r_borrow_out <= 1'b0;
      r_zero       <= 1'b1;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start_in) begin
            r_a      <= a_in;
            r_b      <= b_in;
            r_borrow <= borrow_in;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_state  <= S_RUN;
          end else begin
            r_state  <= S_IDLE;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> DIGIT;
          r_b      <= r_b >> DIGIT;
          r_acc    <= w_acc_next;
          r_borrow <= w_slice_borrow;
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_state      <= S_DONE;
            r_diff       <= w_final_diff;
            r_borrow_out <= w_slice_borrow;
            r_zero       <= (w_final_diff == '0);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy_out   = (r_state == S_RUN);
  assign done_out   = (r_state == S_DONE);
  assign diff_out   = r_diff;
  assign borrow_out = r_borrow_out;
  assign zero_out   = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: DIGIT=4 main instance plus
// DIGIT=1 and DIGIT=16 instances sharing a secondary stimulus stream.
module tb_serial_subtractor;

  typedef struct packed {
    logic [15:0] d;
    logic        b;
    logic        z;
    logic [31:0] c;
  } exp_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        bi;
    logic [15:0] d;
    logic        bo;
    logic        z;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [31:0] cyc = 0;
  logic rst_seen = 1'b1;
  int n_tests = 0;
  int n_fail = 0;

  exp_t q4[$];
  exp_t q1[$];
  exp_t q16[$];
  logic [17:0] h4  = {16'h0, 1'b0, 1'b1};
  logic [17:0] h1  = {16'h0, 1'b0, 1'b1};
  logic [17:0] h16 = {16'h0, 1'b0, 1'b1};

  // main DUT signals
  logic start4, bi4;
  logic [15:0] a4, b4;
  logic busy4, done4, bout4, zero4;
  logic [15:0] diff4;
  // secondary stream
  logic s_start, s_bi;
  logic [15:0] s_a, s_b;
  logic busy1, done1, bout1, zero1;
  logic [15:0] diff1;
  logic busy16, done16, bout16, zero16;
  logic [15:0] diff16;

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) u4 (
    .clk(clk), .rst_n(rst_n), .start_in(start4), .a_in(a4), .b_in(b4),
    .borrow_in(bi4), .busy_out(busy4), .done_out(done4), .diff_out(diff4),
    .borrow_out(bout4), .zero_out(zero4));

  serial_subtractor #(.WIDTH(16), .DIGIT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start_in(s_start), .a_in(s_a), .b_in(s_b),
    .borrow_in(s_bi), .busy_out(busy1), .done_out(done1), .diff_out(diff1),
    .borrow_out(bout1), .zero_out(zero1));

  serial_subtractor #(.WIDTH(16), .DIGIT(16)) u16 (
    .clk(clk), .rst_n(rst_n), .start_in(s_start), .a_in(s_a), .b_in(s_b),
    .borrow_in(s_bi), .busy_out(busy16), .done_out(done16), .diff_out(diff16),
    .borrow_out(bout16), .zero_out(zero16));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= !rst_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected result; saturation replaces an underflowed result with zero.
  function automatic exp_t mk(input logic [15:0] d, input logic bo, input logic z,
                              input logic [31:0] c);
    exp_t e;
`ifdef SERIAL_SUBTRACTOR_SAT_EN
    if (bo) begin
      d = 16'h0;
      z = 1'b1;
    end
`endif
    e.d = d; e.b = bo; e.z = z; e.c = c;
    return e;
  endfunction

  // monitor for the DIGIT=4 instance
  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_seen) begin
      q4.delete();
      h4 = {16'h0, 1'b0, 1'b1};
      chk("rst4", {busy4, done4, diff4, bout4, zero4}, {2'b00, 16'h0, 1'b0, 1'b1});
    end else if (done4) begin
      if (q4.size() == 0) chk("spurious_done4", 1, 0);
      else begin
        e = q4.pop_front();
        chk("res4", {diff4, bout4, zero4}, {e.d, e.b, e.z});
        chk("lat4", cyc, e.c);
        h4 = {e.d, e.b, e.z};
      end
      chk("busy_in_done4", busy4, 0);
    end else begin
      chk("hold4", {diff4, bout4, zero4}, h4);
    end
  end

  // monitor for the DIGIT=1 instance
  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_seen) begin
      q1.delete();
      h1 = {16'h0, 1'b0, 1'b1};
      chk("rst1", {busy1, done1, diff1, bout1, zero1}, {2'b00, 16'h0, 1'b0, 1'b1});
    end else if (done1) begin
      if (q1.size() == 0) chk("spurious_done1", 1, 0);
      else begin
        e = q1.pop_front();
        chk("res1", {diff1, bout1, zero1}, {e.d, e.b, e.z});
        chk("lat1", cyc, e.c);
        h1 = {e.d, e.b, e.z};
      end
      chk("busy_in_done1", busy1, 0);
    end else begin
      chk("hold1", {diff1, bout1, zero1}, h1);
    end
  end

  // monitor for the DIGIT=16 instance
  always @(negedge clk) begin : mon16
    exp_t e;
    if (rst_seen) begin
      q16.delete();
      h16 = {16'h0, 1'b0, 1'b1};
      chk("rst16", {busy16, done16, diff16, bout16, zero16}, {2'b00, 16'h0, 1'b0, 1'b1});
    end else if (done16) begin
      if (q16.size() == 0) chk("spurious_done16", 1, 0);
      else begin
        e = q16.pop_front();
        chk("res16", {diff16, bout16, zero16}, {e.d, e.b, e.z});
        chk("lat16", cyc, e.c);
        h16 = {e.d, e.b, e.z};
      end
      chk("busy_in_done16", busy16, 0);
    end else begin
      chk("hold16", {diff16, bout16, zero16}, h16);
    end
  end

  task automatic go(input vec_t v);
    @(negedge clk);
    a4 = v.a; b4 = v.b; bi4 = v.bi; start4 = 1'b1;
    q4.push_back(mk(v.d, v.bo, v.z, cyc + 1 + 4));
    @(negedge clk);
    start4 = 1'b0;
  endtask

  task automatic wait_empty4();
    for (int i = 0; i < 60; i++) begin
      if (q4.size() == 0) break;
      @(negedge clk);
    end
    if (q4.size() != 0) begin
      chk("timeout4", q4.size(), 0);
      q4.delete();
    end
  endtask

  task automatic go_s(input vec_t v);
    @(negedge clk);
    s_a = v.a; s_b = v.b; s_bi = v.bi; s_start = 1'b1;
    q1.push_back(mk(v.d, v.bo, v.z, cyc + 1 + 16));
    q16.push_back(mk(v.d, v.bo, v.z, cyc + 1 + 1));
    @(negedge clk);
    s_start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (q1.size() == 0 && q16.size() == 0) break;
      @(negedge clk);
    end
    if (q1.size() != 0 || q16.size() != 0) begin
      chk("timeout_s", q1.size() + q16.size(), 0);
      q1.delete();
      q16.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  //                   a        b        bi    diff     bo    zero
  vec_t vecs [9] = '{
    '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0},
    '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0},
    '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1},
    '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0},
    '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b0},
    '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0},
    '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0},
    '{16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0},
    '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0}
  };

  vec_t svecs [4] = '{
    '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b1},
    '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0},
    '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0},
    '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0}
  };

  initial begin
    rst_n = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bi4 = 1'b0;
    s_start = 1'b0; s_a = '0; s_b = '0; s_bi = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (svecs[i]) go_s(svecs[i]);

    foreach (vecs[i]) begin
      go(vecs[i]);
      if (i == 0) begin
        // four RUN cycles, then the done pulse
        for (int k = 0; k < 4; k++) begin
          chk("busy_run", {busy4, done4}, 2'b10);
          if (k < 3) @(negedge clk);
        end
        @(negedge clk);
        chk("done_after_run", {busy4, done4}, 2'b01);
      end
      wait_empty4();
      @(negedge clk);
    end

    // start and new operands during RUN are ignored
    go(vecs[0]);
    @(negedge clk);
    chk("busy_before_ignored_start", busy4, 1);
    a4 = 16'hFFFF; b4 = 16'h0001; bi4 = 1'b1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0; a4 = 16'h0000;
    wait_empty4();
    repeat (4) @(negedge clk);

    // reset mid-RUN aborts, then a fresh operation works
    go(vecs[4]);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    go(vecs[5]);
    wait_empty4();
    repeat (2) @(negedge clk);

    // back-to-back through DONE with start held high
    @(negedge clk);
    a4 = 16'h1234; b4 = 16'h0234; bi4 = 1'b0; start4 = 1'b1;
    q4.push_back(mk(16'h1000, 1'b0, 1'b0, cyc + 1 + 4));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done4) break;
    end
    if (!done4) chk("b2b_first_done_timeout", done4, 1);
    a4 = 16'hABCD; b4 = 16'h1234; bi4 = 1'b0;
    q4.push_back(mk(16'h9999, 1'b0, 1'b0, cyc + 1 + 4));
    @(negedge clk);
    chk("b2b_no_idle", busy4, 1);
    start4 = 1'b0;
    wait_empty4();
    repeat (4) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and result width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4: bits processed per clock.
- WIDTH SHALL be an integer multiple of DIGIT.
- N = WIDTH/DIGIT.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port start_in, input, 1 bit: request to subtract the presented operands.
REQ-006 The block SHALL have port a_in, input, WIDTH bits: minuend.
REQ-007 The block SHALL have port b_in, input, WIDTH bits: subtrahend.
REQ-008 The block SHALL have port borrow_in, input, 1 bit: initial borrow into the least-significant digit.
REQ-009 The block SHALL have port busy_out, output, 1 bit: high while an operation is in progress.
REQ-010 The block SHALL have port done_out, output, 1 bit: one-cycle pulse; result is valid.
REQ-011 The block SHALL have port diff_out, output, WIDTH bits: result of a_in - b_in - borrow_in.
REQ-012 The block SHALL have port borrow_out, output, 1 bit: final borrow; high means an underflow occurred.
REQ-013 The block SHALL have port zero_out, output, 1 bit: high when diff_out equals 0.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-015 In IDLE or DONE, start_in=1 at a rising edge SHALL do all of the following:
- capture a_in, b_in and borrow_in into internal registers;
- clear the digit counter;
- enter RUN.
REQ-016 In RUN, each rising edge SHALL subtract one DIGIT-bit slice, from least-significant to most-significant:
- the slice SHALL use the registered borrow from the previous slice;
- the slice's difference and borrow SHALL be stored;
- the digit counter SHALL increment.
REQ-017 After the N-th RUN edge, the FSM SHALL enter DONE.
- done_out SHALL be high for exactly that one cycle.
- Latency is N cycles from the accepting edge to done_out high.
REQ-018 On entering DONE, diff_out, borrow_out and zero_out SHALL be updated together.
- They SHALL hold their values until the next DONE.
- They SHALL NOT change during RUN.
REQ-019 From DONE, the FSM SHALL go to IDLE when start_in=0.
- If start_in=1, it SHALL go to RUN and accept new operands on the same edge.
REQ-020 busy_out SHALL be high exactly while the state is RUN.
REQ-021 start_in while in RUN SHALL be ignored.
- Operand inputs while in RUN SHALL have no effect.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH.
- borrow_out SHALL be 1 if and only if a_in < b_in + borrow_in as unsigned values.
REQ-023 The result SHALL be identical for every legal DIGIT, including DIGIT=1 and DIGIT=WIDTH (N=1).

Reset
REQ-024 While rst_n=0 at a rising edge, the following SHALL apply:
- state SHALL become IDLE;
- busy_out, done_out and borrow_out SHALL be 0;
- diff_out SHALL be 0;
- zero_out SHALL be 1;
- the digit counter and operand registers SHALL be cleared.
REQ-025 Reset asserted during RUN SHALL abort the operation with no done_out pulse.
REQ-026 Reset SHALL take priority over start_in on the same edge.

Configuration
REQ-027 The macro SERIAL_SUBTRACTOR_SAT_EN SHALL select underflow behaviour.
- When defined and the final borrow is 1, diff_out SHALL be forced to 0, zero_out SHALL be 1, and borrow_out SHALL still be 1.
- When undefined, diff_out SHALL be the wrapped modulo-2^WIDTH result.

Verification
REQ-028 With WIDTH=16, DIGIT=4: a=0x1234, b=0x0234, borrow_in=0, start for 1 cycle -> busy high for 4 cycles, then done pulse, diff=0x1000, borrow=0, zero=0.
REQ-029 a=0x0000, b=0x0001, borrow_in=0 -> borrow=1; diff=0xFFFF without SAT_EN, or diff=0x0000 and zero=1 with SAT_EN.
REQ-030 a=0x0005, b=0x0004, borrow_in=1 -> diff=0x0000, borrow=0, zero=1; with DIGIT=1 the done pulse comes 16 cycles after acceptance.
REQ-031 Start pulsed again 2 cycles into RUN with different operands -> ignored; the result matches the first operands, and only one done pulse occurs.
REQ-032 rst_n low for 1 cycle during RUN -> no done pulse, all outputs at reset values; a subsequent start computes correctly.
REQ-033 start_in held high through DONE with new operands -> back-to-back operation with no IDLE cycle; second done N cycles after the first.
